// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: sequences one data-memory request per
// load/store, formats load data and registers the MEM/WB outputs.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rd_i,
   input  logic        reg_write_i,
   input  logic        mem_to_reg_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic [31:0] wb_data_o,
   output logic [4:0]  rd_o,
   output logic        reg_write_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               abort_q, abort_d;
   logic [31:0]        ld_q, ld_d;
   logic               req_q, we_q;
   logic [31:0]        addr_q, wdata_q;
   logic [3:0]         be_q;
   logic [1:0]         off_q;
   logic [2:0]         f3_q;
   logic               misalign_q, bus_err_q;
   logic [31:0]        wb_data_q;
   logic [4:0]         rd_q;
   logic               reg_write_q;

   logic               mem_req_c, misal_c, start_c, stall_c, error_c, misal_pulse_c;
   logic [3:0]         be_c;
   logic [31:0]        wdata_c, fmt_c;
   logic [7:0]         byte_c;
   logic [15:0]        half_c;

   // Request decode: alignment check and store lane steering
   always_comb begin
      mem_req_c = mem_read_i | mem_write_i;
      misal_c   = 1'b0;
      be_c      = 4'b1111;
      wdata_c   = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            if (mem_write_i) be_c = 4'b0001 << addr_i[1:0];
            wdata_c = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            misal_c = addr_i[0];
            if (mem_write_i) be_c = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata_i[15:0]}};
         end
         default: begin
            misal_c = (addr_i[1:0] != 2'b00);
         end
      endcase
   end

   // Load data extraction and sign/zero extension
   always_comb begin
      byte_c = dmem_rdata_i[{off_q, 3'b000} +: 8];
      half_c = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (f3_q)
         3'b000:  fmt_c = {{24{byte_c[7]}}, byte_c};
         3'b100:  fmt_c = {24'd0, byte_c};
         3'b001:  fmt_c = {{16{half_c[15]}}, half_c};
         3'b101:  fmt_c = {16'd0, half_c};
         default: fmt_c = dmem_rdata_i;
      endcase
   end

   // Next-state, stall and error decode
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      abort_d       = abort_q;
      ld_d          = ld_q;
      stall_c       = 1'b0;
      error_c       = 1'b0;
      start_c       = 1'b0;
      misal_pulse_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_req_c) begin
               if (misal_c) begin
                  error_c       = 1'b1;
                  misal_pulse_c = 1'b1;
               end else begin
                  stall_c = 1'b1;
                  start_c = 1'b1;
                  state_d = S_ACCESS;
                  cnt_d   = '0;
                  abort_d = 1'b0;
               end
            end
         end
         S_ACCESS: begin
            stall_c = 1'b1;
            if (dmem_ack_i) begin
               state_d = S_DONE;
               ld_d    = fmt_c;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_DONE;
               abort_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            error_c = abort_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state and held memory request
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         abort_q    <= 1'b0;
         ld_q       <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         off_q      <= '0;
         f3_q       <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         abort_q    <= abort_d;
         ld_q       <= ld_d;
         req_q      <= (state_d == S_ACCESS);
         misalign_q <= misal_pulse_c;
         bus_err_q  <= (state_q == S_DONE) && abort_q;
         if (start_c) begin
            we_q    <= mem_write_i;
            addr_q  <= {addr_i[31:2], 2'b00};
            wdata_q <= wdata_c;
            be_q    <= be_c;
            off_q   <= addr_i[1:0];
            f3_q    <= funct3_i;
         end
      end
   end

   // MEM/WB register: loads when not stalled, bubble otherwise
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_data_q   <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
      end else if (stall_c) begin
         wb_data_q   <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
      end else begin
         wb_data_q   <= mem_to_reg_i ? ld_q : addr_i;
         rd_q        <= rd_i;
         reg_write_q <= reg_write_i & ~error_c;
      end
   end

   assign stall_o      = stall_c & ~rst_i;
   assign dmem_req_o   = req_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_wdata_o = wdata_q;
   assign dmem_be_o    = be_q;
   assign wb_data_o    = wb_data_q;
   assign rd_o         = rd_q;
   assign reg_write_o  = reg_write_q;
   assign misalign_o   = misalign_q;
   assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a byte-addressed memory model.
module tb_mem_access_stage;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_read_i, mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic [4:0]  rd_i;
   logic        reg_write_i, mem_to_reg_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic        stall_o;
   logic [31:0] wb_data_o;
   logic [4:0]  rd_o;
   logic        reg_write_o, misalign_o, bus_err_o;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [int unsigned];

   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
      .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
      .stall_o(stall_o), .wb_data_o(wb_data_o), .rd_o(rd_o),
      .reg_write_o(reg_write_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] mb(input int unsigned a);
      if (mem.exists(a)) return mem[a];
      return 8'((a * 37) + 5);
   endfunction

   // One instruction, started just after a falling edge; wait_n<0 means never ack.
   task automatic run(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      input logic rw, input logic m2r, input int wait_n);
      logic        is_mem, mis, err, prev_stall, done;
      int          sz, exp_stall, exp_req, n_stall, n_req;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, ld, wa;
      is_mem = rd_en | wr_en;
      sz     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis    = is_mem && ((a % sz) != 0);
      err    = mis || (is_mem && wait_n < 0);
      exp_req   = (!is_mem || mis) ? 0 : (wait_n < 0 ? TO : wait_n + 1);
      exp_stall = (exp_req == 0) ? 0 : exp_req + 1;
      exp_be = 4'h0;
      for (int k = 0; k < sz; k++) exp_be[(a % 4) + k] = 1'b1;
      if (!wr_en) exp_be = 4'hF;
      exp_wd = (sz == 4) ? wd : (sz == 2) ? {wd[15:0], wd[15:0]} : {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      ld = 32'd0;
      for (int k = 0; k < sz; k++) ld = ld + (32'(mb(a + k)) << (8 * k));
      if (!f3[2] && sz == 1 && ld >= 32'd128)   ld = ld - 32'd256;
      if (!f3[2] && sz == 2 && ld >= 32'd32768) ld = ld - 32'd65536;
      wa = a & ~32'd3;

      mem_read_i = rd_en; mem_write_i = wr_en; funct3_i = f3; addr_i = a;
      wdata_i = wd; rd_i = rd; reg_write_i = rw; mem_to_reg_i = m2r;
      n_stall = 0; n_req = 0; prev_stall = 1'b0; done = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         #1;
         if (prev_stall) begin
            check("bubble_rw", 32'(reg_write_o), 32'd0);
            check("bubble_rd", 32'(rd_o), 32'd0);
            check("bubble_wb", wb_data_o, 32'd0);
         end
         if (dmem_req_o) begin
            check("req_addr", dmem_addr_o, wa);
            check("req_be", 32'(dmem_be_o), 32'(exp_be));
            check("req_we", 32'(dmem_we_o), 32'(wr_en));
            if (wr_en) check("req_wdata", dmem_wdata_o, exp_wd);
            if (wait_n >= 0 && n_req == wait_n) begin
               dmem_ack_i = 1'b1;
               if (wr_en) begin
                  dmem_rdata_i = $urandom;
                  for (int k = 0; k < sz; k++) mem[a + k] = wd[8*k +: 8];
               end else begin
                  dmem_rdata_i = {mb(wa + 3), mb(wa + 2), mb(wa + 1), mb(wa)};
               end
            end
            n_req++;
         end
         prev_stall = stall_o;
         if (stall_o) n_stall++;
         @(negedge clk_i);
         dmem_ack_i = 1'b0;
         if (!prev_stall) done = 1'b1;
      end
      if (!done) check("hang", 32'd0, 32'd1);
      check("stall_cycles", 32'(n_stall), 32'(exp_stall));
      check("req_cycles", 32'(n_req), 32'(exp_req));
      check("reg_write_o", 32'(reg_write_o), 32'(rw & ~err));
      check("rd_o", 32'(rd_o), 32'(rd));
      if (!(m2r && err)) check("wb_data_o", wb_data_o, m2r ? ld : a);
      check("misalign_o", 32'(misalign_o), 32'(mis));
      check("bus_err_o", 32'(bus_err_o), 32'(is_mem && !mis && wait_n < 0));
   endtask

   initial begin
      logic        r, w;
      logic [2:0]  f3;
      logic [31:0] a;
      int          sel, wt;
      rst_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'd0;
      addr_i = '0; wdata_i = '0; rd_i = '0; reg_write_i = 1'b0; mem_to_reg_i = 1'b0;
      dmem_ack_i = 1'b0; dmem_rdata_i = '0;
      @(negedge clk_i); @(negedge clk_i);
      check("rst_req", 32'(dmem_req_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_rw", 32'(reg_write_o), 32'd0);
      check("rst_wb", wb_data_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Directed scenarios
      run(1'b0, 1'b0, 3'd0, 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 0);
      mem[32'h103] = 8'h80; mem[32'h102] = 8'hFF;
      run(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd6, 1'b1, 1'b1, 0);
      check("lb_value", wb_data_o, 32'hFFFF_FF80);
      run(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 3);
      run(1'b1, 1'b0, 3'b010, 32'h301, 32'd0, 5'd7, 1'b1, 1'b1, 0);
      run(1'b1, 1'b0, 3'b101, 32'h402, 32'd0, 5'd8, 1'b1, 1'b1, -1);
      check("after_abort_req", 32'(dmem_req_o), 32'd0);
      run(1'b1, 1'b1, 3'b010, 32'h500, 32'h1122_3344, 5'd9, 1'b0, 1'b0, 1);
      run(1'b1, 1'b0, 3'b100, 32'h501, 32'd0, 5'd10, 1'b1, 1'b1, 2);
      check("store_then_lbu", wb_data_o, 32'h0000_0033);

      // Reset while a request is outstanding
      run(1'b0, 1'b0, 3'd0, 32'h55, 32'd0, 5'd3, 1'b1, 1'b0, 0);
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h600; rd_i = 5'd4;
      reg_write_i = 1'b1; mem_to_reg_i = 1'b1;
      @(negedge clk_i); #1;
      check("pre_rst_req", 32'(dmem_req_o), 32'd1);
      rst_i = 1'b1; #1;
      check("mid_rst_req", 32'(dmem_req_o), 32'd0);
      check("mid_rst_stall", 32'(stall_o), 32'd0);
      check("mid_rst_rw", 32'(reg_write_o), 32'd0);
      check("mid_rst_rd", 32'(rd_o), 32'd0);
      check("mid_rst_wb", wb_data_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0; mem_read_i = 1'b0; reg_write_i = 1'b0; mem_to_reg_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_req", 32'(dmem_req_o), 32'd0);

      // Random instruction stream
      for (int i = 0; i < 200; i++) begin
         sel = $urandom_range(0, 3);
         r = (sel == 1) || (sel == 3);
         w = (sel >= 2);
         if (w) f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
         end
         a  = 32'h800 + 32'($urandom_range(0, 31));
         wt = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
         run(r, w, f3, a, $urandom, 5'($urandom), 1'($urandom), r & ~w, wt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles waiting for dmem_ack_i before abort (range 1..255).
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 mem_read_i / mem_write_i  input  1 each  load / store request from the EX/MEM register.
REQ-005 funct3_i  input  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-006 addr_i  input  32  byte address (ALU result); wdata_i  input  32  store data, LSB-aligned.
REQ-007 rd_i  input  5; reg_write_i  input  1; mem_to_reg_i  input  1  writeback controls from EX/MEM.
REQ-008 dmem_req_o, dmem_we_o  output  1 each; dmem_addr_o  output  32  word address (bits[1:0]=0); dmem_wdata_o  output  32; dmem_be_o  output  4  byte enables.
REQ-009 dmem_ack_i  input  1; dmem_rdata_i  input  32  full word, valid when dmem_ack_i=1.
REQ-010 stall_o  output  1  holds all upstream stages, combinational from state and inputs.
REQ-011 wb_data_o  output  32; rd_o  output  5; reg_write_o  output  1  registered MEM/WB outputs.
REQ-012 misalign_o, bus_err_o  output  1 each  registered one-cycle error pulses.

Function
REQ-013 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-014 Request = mem_read_i|mem_write_i; both asserted shall be treated as store only.
REQ-015 Misaligned = H/HU with addr_i[0]=1, or W with addr_i[1:0]!=0; a misaligned request shall make no memory access, remain in IDLE, pulse misalign_o next cycle, and register reg_write_o=0.
REQ-016 IDLE with aligned request: stall_o=1, next state ACCESS, timeout counter cleared to 0.
REQ-017 ACCESS: dmem_req_o=1, stall_o=1; addr/we/be/wdata stable until ack or abort; counter increments each cycle without ack.
REQ-018 Store lanes: SB be=0001<<addr[1:0], byte replicated to all lanes; SH be=0011 or 1100 per addr[1], halfword replicated; SW be=1111; loads drive be=1111, we=0.
REQ-019 Load formatting: select byte/halfword by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged; captured into an internal register on the ack cycle.
REQ-020 ACCESS with dmem_ack_i=1 (same cycle as first req allowed): next state DONE.
REQ-021 ACCESS with counter = TIMEOUT_CYCLES-1 and no ack: next state DONE with abort flag set; bus_err_o pulses the cycle after entering DONE; that instruction registers reg_write_o=0.
REQ-022 DONE: stall_o=0, dmem_req_o=0, request inputs ignored (same held instruction), next state IDLE.
REQ-023 Output register loads every cycle stall_o=0: rd_o<=rd_i; reg_write_o<=reg_write_i & ~error; wb_data_o<= captured load data if mem_to_reg_i else addr_i.
REQ-024 Cycles with stall_o=1 shall register a bubble: reg_write_o=0, rd_o=0, wb_data_o=0.
REQ-025 Latency: non-memory instruction 1 cycle; load/store with ack in first ACCESS cycle 3 cycles (IDLE, ACCESS, DONE), plus one per wait cycle.
REQ-026 Stores register reg_write_o as reg_write_i (normally 0); no memory effect beyond one ack'd request.

Reset
REQ-027 rst_i=1 shall immediately force state IDLE, counter 0, dmem_req_o=0, stall_o=0, and all registered outputs 0, including mid-ACCESS; no request resumes after release.

Verification
REQ-028 ALU op, reg_write_i=1, rd_i=5, addr_i=0x1234 -> next edge reg_write_o=1, rd_o=5, wb_data_o=0x1234, no dmem_req_o.
REQ-029 LB addr 0x103, ack in first ACCESS cycle, rdata 0x80FF_0000 -> be=1111, dmem_addr_o=0x100, stall 2 cycles, wb_data_o=0xFFFF_FF80.
REQ-030 SH addr 0x202, wdata 0xABCD, ack after 3 wait cycles -> be=1100, dmem_wdata_o=0xABCD_ABCD, stall_o high 5 cycles, one req burst.
REQ-031 LW addr 0x301 -> no dmem_req_o, stall_o=0, misalign_o pulses 1 cycle, reg_write_o=0.
REQ-032 TIMEOUT_CYCLES=4, LHU with no ack -> dmem_req_o high 4 cycles, bus_err_o pulse, reg_write_o=0, FSM back in IDLE.
REQ-033 rst_i asserted during ACCESS -> dmem_req_o and stall_o drop without clock edge; outputs 0.
